input_action_gen: RTL and testbench

//  Converts raw 16-bit USB keycode (two 8-bit HID codes, from nios_system keycode_export) into
//  per-frame game action pulses with DAS-style auto-repeat on cursor moves. Sits directly upstream
//  of gamestate (replaces its raw keycode decode); all actions are aligned to the VGA frame tick.

---
 rtl/input_action_gen.sv | 162 ++++++++++++++++
 tb/tb_input_action_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_action_gen.sv
// input_action_gen: turns a two-slot USB HID keycode into per-frame game
// action pulses aligned to the VGA frame tick.
// Optional feature macro: AUTOREPEAT_EN (DAS/ARR auto-repeat on cursor moves).
// With the macro undefined, moves are one-shot on a fresh press.
module input_action_gen #(
    parameter int         DAS_FRAMES = 12,
    parameter int         ARR_FRAMES = 4,
    parameter int         CNT_W      = 5,
    parameter logic [7:0] KEY_UP     = 8'h1A,
    parameter logic [7:0] KEY_DOWN   = 8'h16,
    parameter logic [7:0] KEY_LEFT   = 8'h04,
    parameter logic [7:0] KEY_RIGHT  = 8'h07,
    parameter logic [7:0] KEY_SWAP   = 8'h2C,
    parameter logic [7:0] KEY_RAISE  = 8'h15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [15:0] keycode,
    output logic        move_up,
    output logic        move_down,
    output logic        move_left,
    output logic        move_right,
    output logic        swap,
    output logic        raise,
    output logic        any_key
);

    // Parameter sanity, evaluated at elaboration
    if (DAS_FRAMES < 1 || ARR_FRAMES < 1 ||
        DAS_FRAMES >= (1 << CNT_W) || ARR_FRAMES >= (1 << CNT_W)) begin : g_param_check
        $error("input_action_gen: DAS_FRAMES/ARR_FRAMES must be >=1 and fit in CNT_W bits");
    end

    // A key slot matches only a real code; 8'h00 means "no key"
    function automatic logic key_hit(input logic [15:0] kc, input logic [7:0] key);
        return (key != 8'h00) && ((kc[7:0] == key) || (kc[15:8] == key));
    endfunction

    logic       s1, s2, s3;
    logic       tick;
    logic [5:0] held;       // 0 up, 1 down, 2 left, 3 right, 4 swap, 5 raise
    logic [4:0] prev_held;
    logic [4:0] new_press;
    logic [3:0] fire;
    logic [3:0] fire_ok;
    logic       ud_conflict, lr_conflict;

    // Frame edge detect: two-flop synchronizer then edge register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= frame_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    assign held = {key_hit(keycode, KEY_RAISE), key_hit(keycode, KEY_SWAP),
                   key_hit(keycode, KEY_RIGHT), key_hit(keycode, KEY_LEFT),
                   key_hit(keycode, KEY_DOWN),  key_hit(keycode, KEY_UP)};
    assign new_press   = held[4:0] & ~prev_held;
    assign ud_conflict = held[0] & held[1];
    assign lr_conflict = held[2] & held[3];

`ifdef AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} dir_state_t;

    dir_state_t       state [4];
    logic [CNT_W-1:0] cnt   [4];

    // Fire decision per direction from its FSM state and the current sample
    always_comb begin
        fire = '0;
        for (int i = 0; i < 4; i++) begin
            case (state[i])
                IDLE:    fire[i] = new_press[i];
                DELAY:   fire[i] = held[i] && (cnt[i] == CNT_W'(DAS_FRAMES));
                REPEAT:  fire[i] = held[i] && (cnt[i] == CNT_W'(ARR_FRAMES));
                default: fire[i] = 1'b0;
            endcase
        end
    end

    // Direction FSMs: advance once per frame tick, counter restarts at 1 on every fire
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < 4; i++) begin
                case (state[i])
                    IDLE: begin
                        if (new_press[i]) begin
                            state[i] <= DELAY;
                            cnt[i]   <= CNT_W'(1);
                        end
                    end
                    DELAY: begin
                        if (!held[i]) begin
                            state[i] <= IDLE;
                        end else if (cnt[i] == CNT_W'(DAS_FRAMES)) begin
                            state[i] <= REPEAT;
                            cnt[i]   <= CNT_W'(1);
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!held[i]) begin
                            state[i] <= IDLE;
                        end else if (cnt[i] == CNT_W'(ARR_FRAMES)) begin
                            cnt[i] <= CNT_W'(1);
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end
`else
    assign fire = new_press[3:0];
`endif

    // Opposing directions held together cancel each other's fires for that frame
    assign fire_ok = fire & ~{lr_conflict, lr_conflict, ud_conflict, ud_conflict};

    // Registered action outputs: pulses last one Clk, levels hold until next tick
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            move_up    <= 1'b0;
            move_down  <= 1'b0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            swap       <= 1'b0;
            raise      <= 1'b0;
            any_key    <= 1'b0;
            prev_held  <= '0;
        end else begin
            move_up    <= tick & fire_ok[0];
            move_down  <= tick & fire_ok[1];
            move_left  <= tick & fire_ok[2];
            move_right <= tick & fire_ok[3];
            swap       <= tick & new_press[4];
            if (tick) begin
                raise     <= held[5];
                any_key   <= |keycode;
                prev_held <= held[4:0];
            end
        end
    end

endmodule

// File: tb/tb_input_action_gen.sv
// Bench for input_action_gen: directed scenarios plus randomized key sequences,
// checked against a frame-level model built on press age arithmetic.
`timescale 1ns/1ps
module tb_input_action_gen;

    localparam int DAS = 12;
    localparam int ARR = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [15:0] keycode;
    logic        move_up, move_down, move_left, move_right, swap, raise, any_key;

    int total = 0;
    int bad   = 0;

    // model state
    logic [4:0] m_prev;
    bit         m_act [4];
    int         m_age [4];
    logic [4:0] exp_p;       // {up, down, left, right, swap}
    logic [1:0] exp_l;       // {raise, any_key}
    int         obs_cnt [5];
    int         exp_cnt [5];

    input_action_gen dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .keycode    (keycode),
        .move_up    (move_up),
        .move_down  (move_down),
        .move_left  (move_left),
        .move_right (move_right),
        .swap       (swap),
        .raise      (raise),
        .any_key    (any_key)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [15:0] kc, input logic [7:0] key);
        return (key != 8'h00) && (kc[7:0] == key || kc[15:8] == key);
    endfunction

    // Does a direction held for 'age' frames since its press frame fire now?
    function automatic bit fires_at(input int age);
`ifdef AUTOREPEAT_EN
        return (age == 0) || (age >= DAS && ((age - DAS) % ARR) == 0);
`else
        return age == 0;
`endif
    endfunction

    function automatic logic [4:0] pulses();
        return {move_up, move_down, move_left, move_right, swap};
    endfunction

    task automatic model_reset();
        m_prev = '0;
        for (int d = 0; d < 4; d++) begin
            m_act[d] = 0;
            m_age[d] = 0;
        end
    endtask

    task automatic model_frame(input logic [15:0] kc);
        logic [5:0] h;
        logic [4:0] nw;
        logic [3:0] f;
        h  = {hit(kc, 8'h15), hit(kc, 8'h2C), hit(kc, 8'h07), hit(kc, 8'h04),
              hit(kc, 8'h16), hit(kc, 8'h1A)};
        nw = h[4:0] & ~m_prev;
        for (int d = 0; d < 4; d++) begin
            if (!h[d]) m_act[d] = 0;
            else if (nw[d]) begin
                m_act[d] = 1;
                m_age[d] = 0;
            end else if (m_act[d]) m_age[d]++;
            f[d] = m_act[d] && fires_at(m_age[d]);
        end
        if (h[0] && h[1]) f[1:0] = 2'b00;
        if (h[2] && h[3]) f[3:2] = 2'b00;
        exp_p  = {f[0], f[1], f[2], f[3], nw[4]};
        exp_l  = {h[5], kc != 16'h0000};
        m_prev = h[4:0];
        for (int i = 0; i < 5; i++) exp_cnt[i] += exp_p[4-i];
    endtask

    // One frame: entered #1 after a rising Clk edge with frame_clk low and settled.
    // The rise is sampled on the next edge; pulses appear after the third edge.
    task automatic do_frame(input logic [15:0] kc);
        logic [4:0] p;
        keycode   = kc;
        frame_clk = 1'b1;
        model_frame(kc);
        repeat (3) @(posedge Clk);
        #1;
        p = pulses();
        for (int i = 0; i < 5; i++) obs_cnt[i] += p[4-i];
        chk("pulses", {11'd0, p}, {11'd0, exp_p});
        chk("levels", {14'd0, raise, any_key}, {14'd0, exp_l});
        @(posedge Clk);
        #1;
        chk("pulse_width", {11'd0, pulses()}, 16'd0);
        frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic chk_counts(input string tag);
        for (int i = 0; i < 5; i++) chk(tag, 16'(obs_cnt[i]), 16'(exp_cnt[i]));
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 5; i++) begin
            obs_cnt[i] = 0;
            exp_cnt[i] = 0;
        end
    endtask

    function automatic logic [7:0] pick_code();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h1A;
            2: return 8'h16;
            3: return 8'h04;
            4: return 8'h07;
            5: return 8'h2C;
            6: return 8'h15;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] kc;
        int          n;
        Reset     = 1'b1;
        frame_clk = 1'b0;
        keycode   = 16'h0004;
        model_reset();
        clr_counts();
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_state", {9'd0, pulses(), raise, any_key}, 16'd0);
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;

        // Left held 30 frames: one-shot, or DAS/ARR cadence when auto-repeat is built in
        clr_counts();
        for (int i = 0; i < 30; i++) do_frame(16'h0004);
`ifdef AUTOREPEAT_EN
        chk("left_30_count", 16'(obs_cnt[2]), 16'd6);
`else
        chk("left_30_count", 16'(obs_cnt[2]), 16'd1);
`endif
        chk_counts("left_30_model");
        do_frame(16'h0000);

        // Swap held 20 frames fires exactly once
        clr_counts();
        for (int i = 0; i < 20; i++) do_frame(16'h2C00);
        chk("swap_once", 16'(obs_cnt[4]), 16'd1);
        do_frame(16'h0000);

        // Left+right conflict, then right alone continuing its own cadence
        clr_counts();
        for (int i = 0; i < 20; i++) do_frame(16'h0704);
        chk("lr_suppressed", 16'(obs_cnt[2] + obs_cnt[3]), 16'd0);
        for (int i = 0; i < 12; i++) do_frame(16'h0007);
        chk_counts("lr_then_right");
        do_frame(16'h0000);

        // Up and swap in the same frame, raise low, any_key high
        do_frame(16'h1A2C);
        do_frame(16'h0000);

        // Raise level follows sampled key, then async reset mid-frame
        do_frame(16'h0015);
        chk("raise_level", {15'd0, raise}, 16'd1);
        keycode   = 16'h0015;
        frame_clk = 1'b1;
        #3;
        Reset = 1'b1;
        #1;
        chk("async_reset", {9'd0, pulses(), raise, any_key}, 16'd0);
        model_reset();
        frame_clk = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;

        // Key held through reset counts as new on the first tick after release
        clr_counts();
        for (int i = 0; i < 30; i++) do_frame(16'h0016);
        chk_counts("down_after_reset");
        do_frame(16'h0000);

        // Randomized key sequences with held runs long enough to reach repeats
        clr_counts();
        for (int s = 0; s < 40; s++) begin
            kc = {pick_code(), pick_code()};
            n  = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) do_frame(kc);
        end
        chk_counts("random_counts");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
